sha256_pad_arbiter: RTL and testbench

Shares a single `sha256_padder` between `num_req_p` independent byte-stream requesters, one whole message at a time. The block grants the padder to one requester per message in round-robin order and muxes that requester's bytes into the padder. It returns the padder's 512-bit blocks downstream, tagged with the owner id and a last-block flag. The grant is released only after the message's final padded block has been accepted, so blocks of different messages never interleave.

---
 rtl/sha256_pad_arbiter_if.sv | 37 +++
 rtl/sha256_pad_arbiter.sv | 152 +++++++++++++++
 tb/tb_sha256_pad_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pad_arbiter_if.sv
// Handshake bundle between the requesters, the shared SHA-256 padder and the
// downstream block consumer; the arbiter takes the slave view.
interface sha256_pad_arbiter_if #(
  parameter int num_req_p  = 2,
  parameter int id_width_p = (num_req_p > 1) ? $clog2(num_req_p) : 1
);
  logic [num_req_p-1:0]   req_valid_i;
  logic [8*num_req_p-1:0] req_byte_i;
  logic [num_req_p-1:0]   req_last_i;
  logic [num_req_p-1:0]   req_ready_o;
  logic                   pad_in_valid_o;
  logic [7:0]             pad_in_o;
  logic                   pad_last_byte_o;
  logic                   pad_in_ready_i;
  logic                   pad_out_valid_i;
  logic [511:0]           pad_out_i;
  logic                   pad_out_ready_o;
  logic                   blk_valid_o;
  logic [511:0]           blk_data_o;
  logic [id_width_p-1:0]  blk_id_o;
  logic                   blk_last_o;
  logic                   blk_ready_i;

  modport slave (
    input  req_valid_i, req_byte_i, req_last_i, pad_in_ready_i,
           pad_out_valid_i, pad_out_i, blk_ready_i,
    output req_ready_o, pad_in_valid_o, pad_in_o, pad_last_byte_o,
           pad_out_ready_o, blk_valid_o, blk_data_o, blk_id_o, blk_last_o
  );

  modport master (
    output req_valid_i, req_byte_i, req_last_i, pad_in_ready_i,
           pad_out_valid_i, pad_out_i, blk_ready_i,
    input  req_ready_o, pad_in_valid_o, pad_in_o, pad_last_byte_o,
           pad_out_ready_o, blk_valid_o, blk_data_o, blk_id_o, blk_last_o
  );
endinterface

// File: rtl/sha256_pad_arbiter.sv
// Round-robin arbiter sharing one SHA-256 padder between byte-stream requesters,
// one whole message at a time, returning owner-tagged padded blocks downstream.
module sha256_pad_arbiter #(
  parameter int num_req_p   = 2,
  parameter int id_width_p  = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  parameter int len_width_p = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sha256_pad_arbiter_if.slave bus
);
  localparam int cnt_width_lp = len_width_p - 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [id_width_p-1:0]   grant_q, grant_d;
  logic [id_width_p-1:0]   rr_ptr_q, rr_ptr_d;
  logic [len_width_p-1:0]  byte_cnt_q, byte_cnt_d;
  logic [cnt_width_lp-1:0] blk_cnt_q, blk_cnt_d;
  logic [cnt_width_lp-1:0] blk_total_q, blk_total_d;

  logic [num_req_p-1:0]    sel_s;
  logic                    g_valid_s;
  logic                    g_last_s;
  logic [7:0]              g_byte_s;
  logic                    pick_hit_s;
  logic                    hi_hit_s;
  logic [id_width_p-1:0]   hi_pick_s;
  logic [id_width_p-1:0]   lo_pick_s;
  logic [id_width_p-1:0]   pick_s;
  logic                    feed_s;
  logic                    busy_s;
  logic                    byte_hs_s;
  logic                    blk_hs_s;
  logic                    blk_last_s;
  logic [len_width_p:0]    n_plus8_s;

  // Owner one-hot select and the granted requester's byte-path signals.
  always_comb begin
    sel_s     = '0;
    g_valid_s = 1'b0;
    g_last_s  = 1'b0;
    g_byte_s  = 8'h00;
    for (int k = 0; k < num_req_p; k++) begin
      sel_s[k]  = (grant_q == id_width_p'(k));
      g_valid_s = g_valid_s | (sel_s[k] & bus.req_valid_i[k]);
      g_last_s  = g_last_s | (sel_s[k] & bus.req_last_i[k]);
      g_byte_s  = g_byte_s | (sel_s[k] ? bus.req_byte_i[8*k +: 8] : 8'h00);
    end
  end

  // Cyclic search: lowest valid index at or above rr_ptr, else lowest valid overall.
  always_comb begin
    pick_hit_s = 1'b0;
    hi_hit_s   = 1'b0;
    hi_pick_s  = '0;
    lo_pick_s  = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      lo_pick_s  = bus.req_valid_i[k] ? id_width_p'(k) : lo_pick_s;
      pick_hit_s = pick_hit_s | bus.req_valid_i[k];
      hi_pick_s  = (bus.req_valid_i[k] && (id_width_p'(k) >= rr_ptr_q)) ? id_width_p'(k) : hi_pick_s;
      hi_hit_s   = hi_hit_s | (bus.req_valid_i[k] && (id_width_p'(k) >= rr_ptr_q));
    end
    pick_s = hi_hit_s ? hi_pick_s : lo_pick_s;
  end

  assign feed_s     = (state_q == FEED);
  assign busy_s     = (state_q == FEED) || (state_q == DRAIN);
  assign byte_hs_s  = feed_s && g_valid_s && bus.pad_in_ready_i;
  assign blk_hs_s   = busy_s && bus.pad_out_valid_i && bus.blk_ready_i;
  assign blk_last_s = (state_q == DRAIN) && (blk_cnt_q == (blk_total_q - cnt_width_lp'(1'b1)));
  // n + 8 with n = byte_cnt + 1; one spare bit keeps the top of the range exact.
  assign n_plus8_s  = {1'b0, byte_cnt_q} + {{(len_width_p-3){1'b0}}, 4'd9};

  // Next-state and counter update for the IDLE/FEED/DRAIN message FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    blk_total_d = blk_total_q;
    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        blk_cnt_d  = '0;
        if (pick_hit_s) begin
          grant_d = pick_s;
          state_d = FEED;
        end else begin
          state_d = IDLE;
        end
      end
      FEED: begin
        byte_cnt_d = byte_cnt_q + len_width_p'(byte_hs_s);
        blk_cnt_d  = blk_cnt_q + cnt_width_lp'(blk_hs_s);
        if (byte_hs_s && g_last_s) begin
          blk_total_d = n_plus8_s[len_width_p:6] + cnt_width_lp'(1'b1);
          state_d     = DRAIN;
        end else begin
          state_d = FEED;
        end
      end
      DRAIN: begin
        blk_cnt_d = blk_cnt_q + cnt_width_lp'(blk_hs_s);
        if (blk_hs_s && blk_last_s) begin
          rr_ptr_d = (grant_q == id_width_p'(num_req_p - 1)) ? '0 : grant_q + id_width_p'(1'b1);
          state_d  = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      blk_total_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      blk_total_q <= blk_total_d;
    end
  end

  assign bus.req_ready_o     = feed_s ? (sel_s & {num_req_p{bus.pad_in_ready_i}}) : '0;
  assign bus.pad_in_valid_o  = feed_s && g_valid_s;
  assign bus.pad_in_o        = feed_s ? g_byte_s : 8'h00;
  assign bus.pad_last_byte_o = feed_s && g_last_s;
  assign bus.pad_out_ready_o = busy_s && bus.blk_ready_i;
  assign bus.blk_valid_o     = busy_s && bus.pad_out_valid_i;
  assign bus.blk_data_o      = bus.pad_out_i;
  assign bus.blk_id_o        = grant_q;
  assign bus.blk_last_o      = blk_last_s;
endmodule

// File: tb/tb_sha256_pad_arbiter.sv
// Directed bench for sha256_pad_arbiter with a behavioural SHA-256 padder behind it.
module tb_sha256_pad_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  sha256_pad_arbiter_if #(.num_req_p(2), .id_width_p(1)) bus ();
  sha256_pad_arbiter #(.num_req_p(2), .id_width_p(1), .len_width_p(32)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural padder: 4-deep block FIFO, accepts bytes while at most one block is queued.
  logic [511:0] pm_fifo [4];
  logic [511:0] pm_cur_q;
  int           pm_fill_q, pm_cnt_q;
  logic [63:0]  pm_n_q;
  logic [1:0]   pm_rd_q, pm_wr_q;

  assign bus.pad_in_ready_i  = (pm_cnt_q <= 1);
  assign bus.pad_out_valid_i = (pm_cnt_q != 0);
  assign bus.pad_out_i       = pm_fifo[pm_rd_q];

  always @(posedge clk) begin : padder_model
    logic [511:0] cur, p0, p1;
    int fill, np, pop;
    logic [63:0] n;
    if (rst) begin
      pm_cur_q <= '0; pm_fill_q <= 0; pm_n_q <= '0;
      pm_rd_q <= 2'd0; pm_wr_q <= 2'd0; pm_cnt_q <= 0;
    end else begin
      cur = pm_cur_q; fill = pm_fill_q; n = pm_n_q; np = 0; p0 = '0; p1 = '0;
      pop = (bus.pad_out_valid_i && bus.pad_out_ready_o) ? 1 : 0;
      if (bus.pad_in_valid_o && bus.pad_in_ready_i) begin
        cur = cur | ({504'd0, bus.pad_in_o} << (8 * (63 - fill)));
        fill = fill + 1; n = n + 64'd1;
        if (fill == 64) begin p0 = cur; np = 1; cur = '0; fill = 0; end
        if (bus.pad_last_byte_o) begin
          cur = cur | ({504'd0, 8'h80} << (8 * (63 - fill)));
          if (fill >= 56) begin
            if (np == 0) p0 = cur; else p1 = cur;
            np = np + 1; cur = '0;
          end
          cur[63:0] = n << 3;
          if (np == 0) p0 = cur; else p1 = cur;
          np = np + 1; cur = '0; fill = 0; n = '0;
        end
      end
      if (np >= 1) pm_fifo[pm_wr_q] <= p0;
      if (np == 2) pm_fifo[pm_wr_q + 2'd1] <= p1;
      pm_wr_q   <= pm_wr_q + 2'(np);
      pm_rd_q   <= pm_rd_q + 2'(pop);
      pm_cnt_q  <= pm_cnt_q + np - pop;
      pm_cur_q  <= cur; pm_fill_q <= fill; pm_n_q <= n;
    end
  end

  // Observations collected by run() and judged by the test tasks.
  logic [511:0] got_data [$];
  int           got_id [$];
  bit           got_last [$];
  int           grants [$];
  int           gaps [$];
  int           cross_ready, bp_seen, bp_changes, bp_oready, first_cyc;
  bit           timed_out;

  task automatic do_reset();
    rst = 1'b1; bus.req_valid_i = '0; bus.req_last_i = '0; bus.req_byte_i = '0; bus.blk_ready_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives both requesters (n messages of len bytes, byte i = base + i) and the block sink.
  task automatic run(input int len0, n0, base0, len1, n1, base1, bp_len, abort_after, max_cyc);
    int len [2], left [2], base [2], pos [2];
    int owner, bytes_total, lasts_seen, last_blk_cyc;
    logic [511:0] bp_ref;
    len[0] = len0; len[1] = len1; left[0] = n0; left[1] = n1;
    base[0] = base0; base[1] = base1; pos[0] = 0; pos[1] = 0;
    got_data.delete(); got_id.delete(); got_last.delete(); grants.delete(); gaps.delete();
    cross_ready = 0; bp_seen = 0; bp_changes = 0; bp_oready = 0; first_cyc = -1;
    timed_out = 1'b1; owner = -1; bytes_total = 0; lasts_seen = 0; last_blk_cyc = -1000;
    bp_ref = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        bus.req_valid_i[k]      = (left[k] > 0);
        bus.req_byte_i[8*k +: 8] = 8'(base[k] + pos[k]);
        bus.req_last_i[k]       = (pos[k] == len[k] - 1);
      end
      bus.blk_ready_i = (bp_seen >= bp_len);
      @(negedge clk);
      if (bus.req_ready_o == 2'b11) cross_ready++;
      for (int k = 0; k < 2; k++) begin
        if (owner >= 0 && k != owner && bus.req_ready_o[k]) cross_ready++;
        if (bus.req_valid_i[k] && bus.req_ready_o[k]) begin
          if (pos[k] == 0) begin
            grants.push_back(k); gaps.push_back(cyc - last_blk_cyc); owner = k;
            if (first_cyc < 0) first_cyc = cyc;
          end
          bytes_total++;
          if (pos[k] == len[k] - 1) begin pos[k] = 0; left[k]--; end
          else pos[k]++;
        end
      end
      if (!bus.blk_ready_i && bus.blk_valid_o) begin
        if (bp_seen == 0) bp_ref = bus.blk_data_o;
        else if (bus.blk_data_o !== bp_ref) bp_changes++;
        if (bus.pad_out_ready_o) bp_oready++;
        bp_seen++;
      end
      if (bus.blk_valid_o && bus.blk_ready_i) begin
        got_data.push_back(bus.blk_data_o); got_id.push_back(int'(bus.blk_id_o));
        got_last.push_back(bus.blk_last_o);
        if (bus.blk_last_o) begin lasts_seen++; owner = -1; last_blk_cyc = cyc; end
      end
      @(posedge clk); #1;
      if (abort_after > 0 && bytes_total >= abort_after) begin timed_out = 1'b0; break; end
      if (abort_after == 0 && lasts_seen == n0 + n1 && left[0] == 0 && left[1] == 0) begin
        timed_out = 1'b0; break;
      end
    end
    bus.req_valid_i = '0; bus.blk_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req_valid_i = 2'b11; bus.req_byte_i = 16'hA5A5; bus.req_last_i = 2'b11;
    bus.blk_ready_i = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    tests_run++; if (bus.req_ready_o !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready_o); end
    tests_run++; if (bus.pad_in_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_pad_in_valid: got %b expected 0", bus.pad_in_valid_o); end
    tests_run++; if (bus.pad_in_o !== 8'h00) begin tests_failed++; $display("FAIL reset_pad_in: got %h expected 00", bus.pad_in_o); end
    tests_run++; if (bus.pad_last_byte_o !== 1'b0) begin tests_failed++; $display("FAIL reset_pad_last: got %b expected 0", bus.pad_last_byte_o); end
    tests_run++; if (bus.pad_out_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_pad_out_ready: got %b expected 0", bus.pad_out_ready_o); end
    tests_run++; if (bus.blk_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_blk_valid: got %b expected 0", bus.blk_valid_o); end
    tests_run++; if (bus.blk_id_o !== 1'b0) begin tests_failed++; $display("FAIL reset_blk_id: got %b expected 0", bus.blk_id_o); end
    tests_run++; if (bus.blk_last_o !== 1'b0) begin tests_failed++; $display("FAIL reset_blk_last: got %b expected 0", bus.blk_last_o); end
    #1 rst = 1'b0; bus.req_valid_i = '0; bus.req_last_i = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    logic [511:0] exp_blk;
    exp_blk = {32'h6162_6380, 416'd0, 64'h0000_0000_0000_0018};
    run(3, 1, 32'h61, 0, 0, 0, 0, 0, 200);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL abc_timeout: got %b expected 0", timed_out); end
    tests_run++; if (got_id.size() !== 1) begin tests_failed++; $display("FAIL abc_count: got %0d expected 1", got_id.size()); end
    if (got_id.size() > 0) begin
      tests_run++; if (got_id[0] !== 0) begin tests_failed++; $display("FAIL abc_id: got %0d expected 0", got_id[0]); end
      tests_run++; if (got_last[0] !== 1'b1) begin tests_failed++; $display("FAIL abc_last: got %b expected 1", got_last[0]); end
      tests_run++; if (got_data[0] !== exp_blk) begin tests_failed++; $display("FAIL abc_data: got %h expected %h", got_data[0], exp_blk); end
    end
    tests_run++; if (first_cyc !== 1) begin tests_failed++; $display("FAIL abc_grant_latency: got %0d expected 1", first_cyc); end
  endtask

  task automatic test_lengths();
    int lens [4] = '{55, 56, 64, 120};
    int nb   [4] = '{1, 2, 2, 3};
    int who  [4] = '{0, 0, 0, 1};
    for (int t = 0; t < 4; t++) begin
      if (who[t] == 0) run(lens[t], 1, 32'h20, 0, 0, 0, 0, 0, 2000);
      else             run(0, 0, 0, lens[t], 1, 32'h30, 0, 0, 2000);
      tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL len%0d_timeout: got %b expected 0", lens[t], timed_out); end
      tests_run++; if (got_id.size() !== nb[t]) begin tests_failed++; $display("FAIL len%0d_count: got %0d expected %0d", lens[t], got_id.size(), nb[t]); end
      for (int i = 0; i < got_id.size(); i++) begin
        tests_run++; if (got_last[i] !== (i == nb[t] - 1)) begin tests_failed++; $display("FAIL len%0d_last[%0d]: got %b expected %b", lens[t], i, got_last[i], (i == nb[t] - 1)); end
        tests_run++; if (got_id[i] !== who[t]) begin tests_failed++; $display("FAIL len%0d_id[%0d]: got %0d expected %0d", lens[t], i, got_id[i], who[t]); end
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    run(3, 1, 32'h61, 3, 1, 32'h41, 0, 0, 400);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL cont_timeout: got %b expected 0", timed_out); end
    tests_run++; if (cross_ready !== 0) begin tests_failed++; $display("FAIL cont_cross_ready: got %0d expected 0", cross_ready); end
    tests_run++; if (grants.size() !== 2) begin tests_failed++; $display("FAIL cont_grants: got %0d expected 2", grants.size()); end
    tests_run++; if (got_id.size() !== 2) begin tests_failed++; $display("FAIL cont_blocks: got %0d expected 2", got_id.size()); end
    if (grants.size() == 2 && got_id.size() == 2) begin
      tests_run++; if (grants[0] !== 0) begin tests_failed++; $display("FAIL cont_first_grant: got %0d expected 0", grants[0]); end
      tests_run++; if (got_id[0] !== 0 || got_id[1] !== 1) begin tests_failed++; $display("FAIL cont_ids: got %0d,%0d expected 0,1", got_id[0], got_id[1]); end
      tests_run++; if (got_last[1] !== 1'b1) begin tests_failed++; $display("FAIL cont_last1: got %b expected 1", got_last[1]); end
      tests_run++; if (gaps[1] !== 2) begin tests_failed++; $display("FAIL cont_turnaround: got %0d expected 2", gaps[1]); end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    run(5, 4, 32'h01, 5, 4, 32'h81, 0, 0, 2000);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL fair_timeout: got %b expected 0", timed_out); end
    tests_run++; if (grants.size() !== 8) begin tests_failed++; $display("FAIL fair_count: got %0d expected 8", grants.size()); end
    for (int i = 0; i < grants.size(); i++) begin
      tests_run++; if (grants[i] !== i % 2) begin tests_failed++; $display("FAIL fair_grant[%0d]: got %0d expected %0d", i, grants[i], i % 2); end
    end
    tests_run++; if (cross_ready !== 0) begin tests_failed++; $display("FAIL fair_cross_ready: got %0d expected 0", cross_ready); end
  endtask

  task automatic test_backpressure();
    logic [511:0] exp_blk;
    exp_blk = '0;
    for (int i = 0; i < 10; i++) exp_blk = exp_blk | ({504'd0, 8'(8'h10 + i)} << (8 * (63 - i)));
    exp_blk = exp_blk | ({504'd0, 8'h80} << (8 * (63 - 10)));
    exp_blk[63:0] = 64'd80;
    run(10, 1, 32'h10, 0, 0, 0, 10, 0, 500);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout: got %b expected 0", timed_out); end
    tests_run++; if (bp_seen !== 10) begin tests_failed++; $display("FAIL bp_held_cycles: got %0d expected 10", bp_seen); end
    tests_run++; if (bp_oready !== 0) begin tests_failed++; $display("FAIL bp_pad_out_ready: got %0d expected 0", bp_oready); end
    tests_run++; if (bp_changes !== 0) begin tests_failed++; $display("FAIL bp_data_stable: got %0d expected 0", bp_changes); end
    tests_run++; if (got_id.size() !== 1) begin tests_failed++; $display("FAIL bp_count: got %0d expected 1", got_id.size()); end
    if (got_id.size() == 1) begin
      tests_run++; if (got_last[0] !== 1'b1) begin tests_failed++; $display("FAIL bp_last: got %b expected 1", got_last[0]); end
      tests_run++; if (got_data[0] !== exp_blk) begin tests_failed++; $display("FAIL bp_data: got %h expected %h", got_data[0], exp_blk); end
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] exp_blk;
    exp_blk = {32'h6162_6380, 416'd0, 64'h0000_0000_0000_0018};
    run(0, 0, 0, 30, 1, 32'h50, 0, 20, 400);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL rstmid_abort: got %b expected 0", timed_out); end
    rst = 1'b1; bus.req_valid_i = 2'b10; bus.req_last_i = 2'b00;
    @(posedge clk); @(negedge clk);
    tests_run++; if (bus.req_ready_o !== 2'b00) begin tests_failed++; $display("FAIL rstmid_req_ready: got %b expected 00", bus.req_ready_o); end
    tests_run++; if (bus.pad_in_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_pad_in_valid: got %b expected 0", bus.pad_in_valid_o); end
    tests_run++; if (bus.pad_in_o !== 8'h00) begin tests_failed++; $display("FAIL rstmid_pad_in: got %h expected 00", bus.pad_in_o); end
    tests_run++; if (bus.blk_id_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_blk_id: got %b expected 0", bus.blk_id_o); end
    tests_run++; if (bus.blk_valid_o !== 1'b0 || bus.blk_last_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_blk: got %b%b expected 00", bus.blk_valid_o, bus.blk_last_o); end
    #1 rst = 1'b0; bus.req_valid_i = '0;
    @(posedge clk); #1;
    run(3, 1, 32'h61, 3, 1, 32'h71, 0, 0, 400);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL rstmid_timeout: got %b expected 0", timed_out); end
    tests_run++; if (grants.size() < 1 || grants[0] !== 0) begin tests_failed++; $display("FAIL rstmid_rr_ptr: got %0d expected 0", (grants.size() > 0) ? grants[0] : -1); end
    tests_run++; if (got_id.size() < 1 || got_data[0] !== exp_blk) begin tests_failed++; $display("FAIL rstmid_abc_data: got %h expected %h", (got_data.size() > 0) ? got_data[0] : 512'd0, exp_blk); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i = '0; bus.req_byte_i = '0; bus.req_last_i = '0; bus.blk_ready_i = 1'b1;
    test_reset();
    test_abc();
    test_lengths();
    test_contention();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
